// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter slice.
// Width defaults, limits and the binary-to-Gray encoder function.
package gray_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // Operates at full width; callers zero-extend and truncate.
    // A zero-extended MSB keeps g[msb] = b[msb].
    function automatic logic [WIDTH_MAX-1:0] bin_to_gray(
        input logic [WIDTH_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_counter_bin2gray.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide.
// Holds no state; the counter registers its output.
module bin2gray
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g
);

    assign g = WIDTH'(bin_to_gray(WIDTH_MAX'(b)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output and wrap pulse.
// Gray is encoded from the next-state value so it tracks bin exactly.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // Next count: load beats counting, counting beats hold.
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        priority case (1'b1)
            load: begin
                bin_nxt = load_val;
            end
            en: begin
                if (up) begin
                    bin_nxt  = bin + WIDTH'(1);
                    wrap_nxt = &bin;
                end else begin
                    bin_nxt  = bin - WIDTH'(1);
                    wrap_nxt = ~|bin;
                end
            end
            default: ;
        endcase
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_enc (
        .b (bin_nxt),
        .g (gray_nxt)
    );

    // Count, Gray and wrap registers; reset clears all at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
- REQ-001 SHALL have parameter: WIDTH, default 4, counter width in bits; legal range 2..16.
- REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
- REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
- REQ-004 SHALL have port: en  input  1  count enable; one step per cycle while high.
- REQ-005 SHALL have port: up  input  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
- REQ-006 SHALL have port: load  input  1  synchronous load strobe.
- REQ-007 SHALL have port: load_val  input  WIDTH  binary value loaded when load=1.
- REQ-008 SHALL have port: bin  output  WIDTH  registered binary count.
- REQ-009 SHALL have port: gray  output  WIDTH  registered Gray encoding of bin.
- REQ-010 SHALL have port: wrap  output  1  registered one-cycle wrap pulse.

Function
- REQ-011 SHALL hold the count in a WIDTH-bit binary register; arithmetic SHALL be modulo 2^WIDTH.
- REQ-012 SHALL compute the Gray code as g[i] = b[i] XOR b[i+1] for i < WIDTH-1, and g[WIDTH-1] = b[WIDTH-1].
- REQ-013 SHALL register gray from the next-state binary value, so gray always equals the encoding of bin in the same cycle: zero relative latency, no combinational path from inputs to outputs.
- REQ-014 Priority per edge SHALL be: load > en > hold.
- REQ-015 load=1: bin SHALL become load_val and gray SHALL become its encoding on the next edge, regardless of en and up.
- REQ-016 load=0, en=1, up=1: bin SHALL become bin+1; load=0, en=1, up=0: bin SHALL become bin-1.
- REQ-017 load=0, en=0: bin, gray SHALL hold; wrap SHALL be 0.
- REQ-018 wrap SHALL be 1 for exactly the cycle after a counting step from all-ones to zero (up) or from zero to all-ones (down); 0 otherwise.
- REQ-019 A load SHALL never assert wrap, including a load of 0 while bin is all-ones.
- REQ-020 Every counting step SHALL change exactly one bit of gray, including across the wrap boundary.
- REQ-021 Continuous enable SHALL produce a new step every cycle; there are no idle or bubble cycles.

Reset
- REQ-022 rst_n=0 SHALL immediately, asynchronously force bin=0, gray=0, wrap=0, including mid-count.
- REQ-023 While rst_n=0, all inputs SHALL be ignored.
- REQ-024 The first step SHALL occur on the first rising edge after rst_n rises with en=1 or load=1.

Structure
- REQ-025 Shared package gray_pkg SHALL hold: the WIDTH default, the WIDTH limits, and a pure bin-to-gray function used by RTL and bench alike.
- REQ-026 One sub-module SHALL exist: bin2gray, a combinational WIDTH-parameterised encoder instantiated on the next-state binary value.
- REQ-027 All flops SHALL reside in gray_counter; bin2gray SHALL be flop-free.

Verification (WIDTH=4)
- REQ-028 Reset, then en=1, up=1 for 16 cycles:
  - gray SHALL follow 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000;
  - wrap SHALL be 1 only in the cycle where bin returns to 0000.
- REQ-029 From reset, en=1, up=0 for one cycle: bin SHALL be 1111, gray 1000, wrap 1; the next cycle SHALL give bin 1110, gray 1001, wrap 0.
- REQ-030 With bin=1111, load=1, load_val=0000, en=1: bin SHALL be 0000, gray 0000, wrap 0. With load_val=1010: gray SHALL be 1111.
- REQ-031 With bin=0111, assert rst_n=0 between edges: bin, gray, wrap SHALL read 0 before the next clk edge; en=0 for 5 cycles SHALL hold all outputs unchanged.
- REQ-032 Run 200 random cycles of en, up, load and load_val. The bench SHALL check:
  - the single-bit Gray change on every counting step;
  - gray passed through the existing graytobin module equals bin on every cycle;
  - bin matches a modulo-16 reference model.
